// File: rtl/sd_present_state_gen.sv
// Live Present State status bits: command/DAT inhibit, the data-transfer FSM, pin synchronisers and card-detect debounce.
// Status outputs are registered one cycle behind their cause; level outputs trail the pins by two cycles.
module sd_present_state_gen #(
  parameter int BUF_WORDS  = 128,
  parameter int WCNT_W     = 8,
  parameter int BCNT_W     = 16,
  parameter int DEB_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_issue,
  input  logic              cmd_data_present,
  input  logic              cmd_dir_read,
  input  logic              cmd_busy_resp,
  input  logic              cmd_end,
  input  logic [BCNT_W-1:0] blk_count,
  input  logic              dat_blk_done,
  input  logic              dat_busy_in,
  input  logic              buf_word_rd,
  input  logic              buf_word_wr,
  input  logic              abort,
  input  logic              cd_n_raw,
  input  logic              wp_raw,
  input  logic              cmd_raw,
  input  logic [3:0]        dat_raw,
  output logic              cmd_inhibit_cmd,
  output logic              cmd_inhibit_dat,
  output logic              dat_line_active,
  output logic              read_transfer_active,
  output logic              write_transfer_active,
  output logic              buffer_read_enable,
  output logic              buffer_write_enable,
  output logic              card_inserted,
  output logic              card_state_stable,
  output logic              card_detect_level,
  output logic              wp_level,
  output logic              cmd_level,
  output logic [3:0]        dat_level,
  output logic              xfer_complete
);

  localparam int                DCNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DEB_MAX   = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(BUF_WORDS - 1);
  localparam logic [BCNT_W-1:0] ONE_BLK   = BCNT_W'(1);

  typedef enum logic [2:0] {IDLE, WR_FILL, WR_SEND, WR_BUSY, RD_WAIT, RD_DRAIN, R1B} state_t;

  // Detect is synchronised already inverted so every flop resets to 0.
  logic       cdS1, wpS1, cmdS1;
  logic [3:0] datS1;
  logic [DCNT_W-1:0] debCnt;
  logic       insPrev;

  always_ff @(posedge clk) begin
    if (rst) begin
      cdS1 <= 1'b0; card_detect_level <= 1'b0;
      wpS1 <= 1'b0; wp_level <= 1'b0;
      cmdS1 <= 1'b0; cmd_level <= 1'b0;
      datS1 <= '0; dat_level <= '0;
      debCnt <= '0;
      card_state_stable <= 1'b0;
      card_inserted <= 1'b0;
      insPrev <= 1'b0;
    end else begin
      cdS1 <= ~cd_n_raw; card_detect_level <= cdS1;
      wpS1 <= wp_raw;    wp_level <= wpS1;
      cmdS1 <= cmd_raw;  cmd_level <= cmdS1;
      datS1 <= dat_raw;  dat_level <= datS1;
      insPrev <= card_inserted;
      if (cdS1 != card_detect_level) begin
        debCnt <= '0;
        card_state_stable <= 1'b0;
      end else if (debCnt != DEB_MAX) begin
        debCnt <= debCnt + DCNT_W'(1);
      end else begin
        card_state_stable <= 1'b1;
        card_inserted <= card_detect_level;
      end
    end
  end

  state_t            state, stateNext;
  logic [WCNT_W-1:0] wordCnt, wordCntNext;
  logic [BCNT_W-1:0] remBlk, remBlkNext;
  logic              endSeen, endSeenNext, xferNext;
  logic              needsDat, issueOk, cardGone;

  assign needsDat = cmd_data_present | cmd_busy_resp;
  // cmd_end in the same cycle as an issue wins; the issue is dropped.
  assign issueOk  = cmd_issue & ~cmd_end & ~cmd_inhibit_cmd & ~(needsDat & cmd_inhibit_dat);
  assign cardGone = insPrev & ~card_inserted;

  always_comb begin
    stateNext   = state;
    wordCntNext = wordCnt;
    remBlkNext  = remBlk;
    endSeenNext = endSeen;
    xferNext    = 1'b0;
    if (abort || cardGone) begin
      stateNext   = IDLE;
      wordCntNext = '0;
      remBlkNext  = '0;
      endSeenNext = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issueOk && needsDat) begin
            remBlkNext  = (blk_count == '0) ? ONE_BLK : blk_count;
            wordCntNext = '0;
            endSeenNext = 1'b0;
            if (cmd_data_present) stateNext = cmd_dir_read ? RD_WAIT : WR_FILL;
            else                  stateNext = R1B;
          end
        end
        WR_FILL: begin
          if (buf_word_wr) begin
            if (wordCnt == WORD_LAST) begin
              wordCntNext = '0;
              stateNext   = WR_SEND;
            end else begin
              wordCntNext = wordCnt + WCNT_W'(1);
            end
          end
        end
        WR_SEND: begin
          if (dat_blk_done) begin
            remBlkNext = remBlk - ONE_BLK;
            stateNext  = (remBlk == ONE_BLK) ? WR_BUSY : WR_FILL;
          end
        end
        WR_BUSY: begin
          if (!dat_busy_in) begin
            stateNext = IDLE;
            xferNext  = 1'b1;
          end
        end
        RD_WAIT: begin
          if (dat_blk_done) stateNext = RD_DRAIN;
        end
        RD_DRAIN: begin
          if (buf_word_rd) begin
            if (wordCnt == WORD_LAST) begin
              wordCntNext = '0;
              remBlkNext  = remBlk - ONE_BLK;
              if (remBlk == ONE_BLK) begin
                stateNext = IDLE;
                xferNext  = 1'b1;
              end else begin
                stateNext = RD_WAIT;
              end
            end else begin
              wordCntNext = wordCnt + WCNT_W'(1);
            end
          end
        end
        R1B: begin
          if (cmd_end) endSeenNext = 1'b1;
          if ((endSeen || cmd_end) && !dat_busy_in) begin
            stateNext   = IDLE;
            endSeenNext = 1'b0;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wordCnt <= '0;
      remBlk  <= '0;
      endSeen <= 1'b0;
      cmd_inhibit_cmd       <= 1'b0;
      cmd_inhibit_dat       <= 1'b0;
      dat_line_active       <= 1'b0;
      read_transfer_active  <= 1'b0;
      write_transfer_active <= 1'b0;
      buffer_read_enable    <= 1'b0;
      buffer_write_enable   <= 1'b0;
      xfer_complete         <= 1'b0;
    end else begin
      state   <= stateNext;
      wordCnt <= wordCntNext;
      remBlk  <= remBlkNext;
      endSeen <= endSeenNext;
      if (cmd_end)      cmd_inhibit_cmd <= 1'b0;
      else if (issueOk) cmd_inhibit_cmd <= 1'b1;
      cmd_inhibit_dat       <= (stateNext != IDLE);
      dat_line_active       <= (stateNext == WR_SEND) || (stateNext == WR_BUSY) ||
                               (stateNext == RD_WAIT) || (stateNext == R1B);
      read_transfer_active  <= (stateNext == RD_WAIT) || (stateNext == RD_DRAIN);
      write_transfer_active <= (stateNext == WR_FILL) || (stateNext == WR_SEND) ||
                               (stateNext == WR_BUSY);
      buffer_read_enable    <= (stateNext == RD_DRAIN);
      buffer_write_enable   <= (stateNext == WR_FILL);
      xfer_complete         <= xferNext;
    end
  end

endmodule

// File: doc/sd_present_state_gen.md
Name: sd_present_state_gen

Overview:
- Generates the live Present State status bits (offset 024h) of the SD host controller. Its outputs drive the `_in` inputs of the Present State capture register one-to-one.
- Tracks command-line occupancy and runs the data-transfer state machine, which sequences buffer enables, transfer-active flags and DAT-line activity.
- Synchronises the raw card pins and debounces card-detect.
- Sits between the command/DAT engines, the host buffer port and the Present State register.

Parameters:
- BUF_WORDS, 128, 32-bit buffer words per block (512-byte block).
- WCNT_W, 8, width of the buffer word counter; must satisfy 2^WCNT_W > BUF_WORDS.
- BCNT_W, 16, width of the block count.
- DEB_CYCLES, 1024, number of stable card-detect cycles required before the card state is declared stable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cmd_issue  in  1  pulse: host wrote the Command register
- cmd_data_present  in  1  command carries a data phase; qualified by cmd_issue
- cmd_dir_read  in  1  1 = read (card to host); qualified by cmd_issue
- cmd_busy_resp  in  1  R1b response with no data phase; qualified by cmd_issue
- cmd_end  in  1  pulse: response received or timed out
- blk_count  in  BCNT_W  number of blocks; sampled on cmd_issue
- dat_blk_done  in  1  pulse: one block finished on the DAT lines
- dat_busy_in  in  1  DAT0 held low by the card (busy)
- buf_word_rd  in  1  host read one buffer word
- buf_word_wr  in  1  host wrote one buffer word
- abort  in  1  pulse: DAT software reset or abort
- cd_n_raw  in  1  raw card-detect pin, active low
- wp_raw  in  1  raw write-protect pin
- cmd_raw  in  1  raw CMD pin
- dat_raw  in  4  raw DAT[3:0] pins
- cmd_inhibit_cmd  out  1  CMD line in use
- cmd_inhibit_dat  out  1  DAT line reserved
- dat_line_active  out  1  DAT line transferring
- read_transfer_active  out  1  read transfer in progress
- write_transfer_active  out  1  write transfer in progress
- buffer_read_enable  out  1  a full block is readable by the host
- buffer_write_enable  out  1  the buffer is writable by the host
- card_inserted  out  1  debounced card presence
- card_state_stable  out  1  debounce counter is saturated
- card_detect_level  out  1  synchronised cd_n_raw, inverted
- wp_level  out  1  synchronised wp_raw
- cmd_level  out  1  synchronised cmd_raw
- dat_level  out  4  synchronised dat_raw
- xfer_complete  out  1  one-cycle pulse at the normal end of a transfer

Behaviour:
- Reset: every output is 0. The FSM is in IDLE and all counters and synchroniser flops are cleared.
- Pin synchronisers: 2-flop synchronisers on all raw pins. Level outputs lag the pins by 2 cycles.
- Debounce:
  - The counter restarts from 0 whenever the synchronised card-detect value changes, and card_state_stable drops to 0 in that same cycle.
  - When the counter reaches DEB_CYCLES-1, card_state_stable goes to 1 and card_inserted loads the synchronised detect level.
  - While the counter is not saturated, card_inserted holds its previous value.
- cmd_issue acceptance: cmd_issue is accepted only when cmd_inhibit_cmd=0. It is also ignored when the command needs the DAT line (data or busy response) and cmd_inhibit_dat=1. Ignored issues change nothing.
- cmd_inhibit_cmd: set the cycle after an accepted cmd_issue; cleared the cycle after cmd_end. If cmd_end and cmd_issue arrive in the same cycle, cmd_end wins and the issue is ignored.
- cmd_inhibit_dat: set the cycle after an accepted issue with data or busy response; cleared when the FSM returns to IDLE.
- FSM states: IDLE, WR_FILL, WR_SEND, WR_BUSY, RD_WAIT, RD_DRAIN, R1B.
- blk_count handling: the remaining-block count loads blk_count on issue; blk_count=0 is treated as 1.
- IDLE transitions on an accepted issue:
  - write → WR_FILL
  - read → RD_WAIT
  - busy response only → R1B
- WR_FILL: buffer_write_enable=1. Each buf_word_wr increments the word count. The BUF_WORDS-th word goes to WR_SEND and clears the word count.
- WR_SEND: dat_line_active=1. On dat_blk_done the remaining count decrements. It then goes to WR_FILL if blocks remain, otherwise to WR_BUSY.
- WR_BUSY: dat_line_active=1. When dat_busy_in=0 it goes to IDLE and pulses xfer_complete.
- write_transfer_active=1 in WR_FILL, WR_SEND and WR_BUSY.
- RD_WAIT: dat_line_active=1. On dat_blk_done it goes to RD_DRAIN.
- RD_DRAIN: buffer_read_enable=1 and dat_line_active=0. The BUF_WORDS-th buf_word_rd decrements the remaining count. It then goes to RD_WAIT if blocks remain, otherwise to IDLE with an xfer_complete pulse.
- read_transfer_active=1 in RD_WAIT and RD_DRAIN.
- R1B: dat_line_active=1. A sticky flag records cmd_end. The state exits to IDLE in the first cycle where the flag (or cmd_end itself) is set and dat_busy_in=0. No xfer_complete pulse is generated.
- Out-of-window strobes: buf_word_rd and buf_word_wr outside their enable windows are ignored. dat_blk_done in any state other than WR_SEND or RD_WAIT is ignored.
- abort, or a falling edge of card_inserted: the FSM goes to IDLE in the next cycle and clears the counters and cmd_inhibit_dat. No xfer_complete pulse is generated. cmd_inhibit_cmd is unaffected.
- Status outputs are registered and update the cycle after the corresponding state change.

Test Plan:
- Reset → all outputs 0. Hold cd_n_raw=0 for DEB_CYCLES+2 cycles → card_detect_level=1 after 2 cycles; card_state_stable=1 and card_inserted=1 after the debounce period.
- Glitch cd_n_raw for 5 cycles at count 500 → card_state_stable falls and the count restarts; card_inserted stays 1.
- Write, blk_count=2: inhibit_cmd/inhibit_dat go to 1 and buffer_write_enable=1. 128 writes → dat_line_active=1. dat_blk_done → buffer_write_enable=1 again. Repeat, then dat_busy_in 1→0 → IDLE, one xfer_complete pulse, inhibit_dat=0.
- Read, blk_count=0: treated as 1 block. RD_WAIT; dat_blk_done → buffer_read_enable=1. 127 reads leave it at 1; the 128th read → IDLE and xfer_complete.
- cmd_busy_resp: cmd_end arrives while dat_busy_in=1 → inhibit_dat stays 1. dat_busy_in→0 → inhibit_dat=0 with no xfer_complete. A second cmd_issue while inhibit_cmd=1 is ignored.
- Read mid-drain: abort → IDLE the next cycle, all transfer flags 0, no xfer_complete. A subsequent write proceeds normally from a word count of 0.
